// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and status controller for a register-file FIFO.
// Drives write enable and read/write addresses; keeps flags and sticky errors.
module fifo_ctrl #(
    parameter int ADD_WIDTH = 3,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic                 rd,
    input  logic                 flush,
    input  logic                 err_clr,
    output logic                 w_en,
    output logic [ADD_WIDTH-1:0] w_add,
    output logic [ADD_WIDTH-1:0] r_add,
    output logic [ADD_WIDTH:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [ADD_WIDTH:0] FULL_CNT = {1'b1, {ADD_WIDTH{1'b0}}};
    localparam logic [ADD_WIDTH:0] AF_CNT   = (ADD_WIDTH+1)'(AF_THRESH);
    localparam logic [ADD_WIDTH:0] AE_CNT   = (ADD_WIDTH+1)'(AE_THRESH);
    localparam logic [ADD_WIDTH:0] ONE      = (ADD_WIDTH+1)'(1);

    logic [ADD_WIDTH:0] wptr_q, wptr_d;
    logic [ADD_WIDTH:0] rptr_q, rptr_d;
    logic [ADD_WIDTH:0] count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               af_q, af_d;
    logic               ae_q, ae_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               push_ok;
    logic               pop_ok;

    always_comb begin
        push_ok = wr & ~flush & (~full_q | rd);
        pop_ok  = rd & ~flush & ~empty_q;
        wptr_d  = push_ok ? wptr_q + ONE : wptr_q;
        rptr_d  = pop_ok ? rptr_q + ONE : rptr_q;
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - ONE;
        end
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_CNT);
        ae_d    = (count_d <= AE_CNT);
        // a new error in the same cycle as err_clr stays set
        ovf_d = (wr & full_q & ~rd & ~flush) | (ovf_q & ~err_clr);
        udf_d = (rd & empty_q & ~flush) | (udf_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign w_en         = push_ok;
    assign w_add        = wptr_q[ADD_WIDTH-1:0];
    assign r_add        = rptr_q[ADD_WIDTH-1:0];
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a small register-file model for read data.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       flush = 1'b0;
    logic       err_clr = 1'b0;
    logic       w_en;
    logic [2:0] w_add;
    logic [2:0] r_add;
    logic [3:0] count;
    logic       full, empty, almost_full, almost_empty;
    logic       overflow, underflow;

    logic [7:0] wdata = 8'h00;
    logic [7:0] mem [8];
    logic [7:0] r_data;

    int checks = 0;
    int passes = 0;

    fifo_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .flush        (flush),
        .err_clr      (err_clr),
        .w_en         (w_en),
        .w_add        (w_add),
        .r_add        (r_add),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_en) mem[w_add] <= wdata;
    end

    assign r_data = mem[r_add];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_d;
        step();
        step();
        reset = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        chk("rst_wadd", w_add, 0);
        chk("rst_radd", r_add, 0);

        for (int i = 0; i < 8; i++) begin
            wr = 1'b1;
            wdata = 8'((i + 1) * 8'h11);
            #1;
            chk("push_wen", w_en, 1);
            step();
            chk("push_count", count, i + 1);
            chk("push_af", almost_full, (i + 1) >= 6);
            chk("push_ae", almost_empty, (i + 1) <= 1);
            chk("push_full", full, (i + 1) == 8);
            chk("push_empty", empty, 0);
            chk("push_wadd", w_add, (i + 1) % 8);
        end
        wr = 1'b0;

        wr = 1'b1;
        #1;
        chk("ovf_wen", w_en, 0);
        step();
        wr = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 8);
        step();
        chk("ovf_sticky", overflow, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        wr = 1'b1;
        rd = 1'b1;
        wdata = 8'h99;
        #1;
        chk("full_rw_wen", w_en, 1);
        chk("full_rw_rdata", r_data, 8'h11);
        step();
        wr = 1'b0;
        rd = 1'b0;
        chk("full_rw_count", count, 8);
        chk("full_rw_full", full, 1);
        chk("full_rw_radd", r_add, 1);
        chk("full_rw_wadd", w_add, 1);
        chk("full_rw_ovf", overflow, 0);

        for (int j = 0; j < 8; j++) begin
            exp_d = (j < 7) ? 8'((j + 2) * 8'h11) : 8'h99;
            rd = 1'b1;
            #1;
            chk("drain_rdata", r_data, exp_d);
            step();
            chk("drain_count", count, 7 - j);
            chk("drain_ae", almost_empty, (7 - j) <= 1);
            chk("drain_af", almost_full, (7 - j) >= 6);
            chk("drain_empty", empty, j == 7);
            chk("drain_full", full, 0);
        end

        step();
        chk("udf_set", underflow, 1);
        chk("udf_count", count, 0);
        chk("udf_empty", empty, 1);
        rd = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("udf_clr", underflow, 0);

        wr = 1'b1;
        rd = 1'b1;
        wdata = 8'hA5;
        #1;
        chk("empty_rw_wen", w_en, 1);
        step();
        wr = 1'b0;
        rd = 1'b0;
        chk("empty_rw_count", count, 1);
        chk("empty_rw_udf", underflow, 1);
        chk("empty_rw_empty", empty, 0);
        chk("empty_rw_rdata", r_data, 8'hA5);

        wr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wdata = 8'(8'hB0 + k);
            step();
        end
        chk("pre_flush_count", count, 5);
        flush = 1'b1;
        #1;
        chk("flush_wen", w_en, 0);
        step();
        flush = 1'b0;
        wr = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_ae", almost_empty, 1);
        chk("flush_wadd", w_add, 0);
        chk("flush_radd", r_add, 0);
        chk("flush_udf", underflow, 1);

        err_clr = 1'b1;
        rd = 1'b1;
        step();
        err_clr = 1'b0;
        rd = 1'b0;
        chk("set_wins", underflow, 1);

        wr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wdata = 8'(8'hC0 + k);
            step();
        end
        wr = 1'b0;
        chk("pre_rst_count", count, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_ae", almost_empty, 1);
        chk("arst_wadd", w_add, 0);
        chk("arst_radd", r_add, 0);
        chk("arst_udf", underflow, 0);
        step();
        reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
